// File: rtl/mult_sequencer_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ADD,
        SHIFT,
        HOLD
    } mult_state_t;

    localparam int MULT_BITS = 8;

    // Step counter width; never narrower than one bit.
    function automatic int step_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_sequencer_edge_detect.sv
// Registered rising-edge detector; RESET_VAL=1 suppresses an edge from a level held through reset.
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for the signed shift-add multiplier: one-cycle strobes for clear/load/add/sub/shift.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int NUM_BITS   = MULT_BITS,
    parameter bit AUTO_CLEAR = 1'b1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Run,
    input  logic                          ClearA_LoadB,
    input  logic                          M,
    output logic                          Clr_A,
    output logic                          LoadB,
    output logic                          Add,
    output logic                          Sub,
    output logic                          Shift,
    output logic                          Busy,
    output logic                          Done,
    output logic [step_w(NUM_BITS)-1:0]   Step,
    output mult_state_t                   State
);

    localparam int            SW   = step_w(NUM_BITS);
    localparam logic [SW-1:0] LAST = SW'(NUM_BITS - 1);

    mult_state_t   state, state_n;
    logic [SW-1:0] step, step_n;
    logic          run_start;

    edge_detect #(.RESET_VAL(1'b1)) u_run_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (Run),
        .rise  (run_start)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
        end
    end

    always_comb begin
        state_n = state;
        step_n  = step;
        Clr_A   = 1'b0;
        LoadB   = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (run_start) begin
                    state_n = AUTO_CLEAR ? CLEAR : ADD;
                    step_n  = '0;
                end else if (ClearA_LoadB && Reset) begin
                    // Gated by Reset so the strobes stay low while reset is held.
                    Clr_A = 1'b1;
                    LoadB = 1'b1;
                end
            end
            CLEAR: begin
                Busy    = 1'b1;
                Clr_A   = 1'b1;
                state_n = ADD;
            end
            ADD: begin
                Busy    = 1'b1;
                Add     = M;
                // Final iteration weighs the multiplier sign bit negatively.
                Sub     = M && (step == LAST);
                state_n = SHIFT;
            end
            SHIFT: begin
                Busy  = 1'b1;
                Shift = 1'b1;
                if (step == LAST) begin
                    state_n = HOLD;
                    step_n  = '0;
                end else begin
                    state_n = ADD;
                    step_n  = step + 1'b1;
                end
            end
            HOLD: begin
                Done = 1'b1;
                if (!Run) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                step_n  = '0;
            end
        endcase
    end

    assign Step  = step;
    assign State = state;

endmodule
